// File: rtl/vga_timing_gen_if.sv
// Timing bundle produced by vga_timing_gen and consumed by the text/colour stages.
interface vga_timing_gen_if;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       h_end;
  logic       v_end;
  logic       frame_start;

  modport master (
    output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, h_end, v_end, frame_start
  );

  modport slave (
    input p_tick, pixel_x, pixel_y, video_on, hsync, vsync, h_end, v_end, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parameterised VGA timing generator: pixel-tick divider, x/y counters,
// registered active-low syncs aligned with the counters, and frame markers.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int TICK_DIV  = 2
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(TICK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || TICK_DIV < 2) begin : g_param_check
    $error("vga_timing_gen: totals must fit 10-bit counters and TICK_DIV must be >= 2");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             p_tick_q;
  logic [9:0]       x_q, y_q;
  logic [9:0]       x_n, y_n;
  logic             hsync_q, vsync_q;
  logic             frame_start_q;
  logic             h_end, v_end;

  assign h_end = (x_q == H_LAST);
  assign v_end = (y_q == V_LAST);

  // Next counter values; the sync registers decode these so they never lag x/y.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    x_n = x_q;
    y_n = y_q;
    if (p_tick_q) begin
      if (h_end) begin
        x_n = '0;
        y_n = v_end ? '0 : y_q + 10'd1;
      end else begin
        x_n = x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      div_cnt       <= '0;
      p_tick_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt       <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      p_tick_q      <= (div_cnt == DIV_LAST);
      x_q           <= x_n;
      y_q           <= y_n;
      hsync_q       <= !((x_n >= HS_FIRST) && (x_n <= HS_LAST));
      vsync_q       <= !((y_n >= VS_FIRST) && (y_n <= VS_LAST));
      frame_start_q <= p_tick_q && h_end && v_end;
    end
  end

  assign vga.p_tick      = p_tick_q;
  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.video_on    = (x_q < H_VIS) && (y_q < V_VIS);
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.h_end       = h_end;
  assign vga.v_end       = v_end;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny-mode instance,
// both compared every cycle against an arithmetic model of elapsed clocks.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       h_end;
    logic       v_end;
    logic       frame_start;
  } outs_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   k_a, k_b;
  bit   cmp_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if bus_a ();
  vga_timing_gen_if bus_b ();

  vga_timing_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (bus_a.master)
  );

  vga_timing_gen #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
    .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .TICK_DIV  (4)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (bus_b.master)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs after k clock edges since reset release, from plain arithmetic on elapsed ticks.
  function automatic outs_t model(input int k, input int hd, input int hf, input int hsw,
                                  input int hb, input int vd, input int vf, input int vsw,
                                  input int vb, input int td);
    int ht, vt, t, x, y;
    logic tick_prev;
    outs_t o;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    t  = (k >= 1) ? (k - 1) / td : 0;
    x  = t % ht;
    y  = (t / ht) % vt;
    tick_prev     = (k - 1 >= td) && ((k - 1) % td == 0);
    o.p_tick      = (k >= td) && (k % td == 0);
    o.x           = 10'(x);
    o.y           = 10'(y);
    o.video_on    = (x < hd) && (y < vd);
    o.hsync       = !((x >= hd + hf) && (x < hd + hf + hsw));
    o.vsync       = !((y >= vd + vf) && (y < vd + vf + vsw));
    o.h_end       = (x == ht - 1);
    o.v_end       = (y == vt - 1);
    o.frame_start = tick_prev && (t % (ht * vt) == 0);
    return o;
  endfunction

  always @(posedge clk or posedge rst_a)
    if (rst_a) k_a <= 0; else k_a <= k_a + 1;

  always @(posedge clk or posedge rst_b)
    if (rst_b) k_b <= 0; else k_b <= k_b + 1;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle_a",
            {bus_a.p_tick, bus_a.pixel_x, bus_a.pixel_y, bus_a.video_on, bus_a.hsync,
             bus_a.vsync, bus_a.h_end, bus_a.v_end, bus_a.frame_start},
            model(k_a, 640, 16, 96, 48, 480, 10, 2, 33, 2));
      check("cycle_b",
            {bus_b.p_tick, bus_b.pixel_x, bus_b.pixel_y, bus_b.video_on, bus_b.hsync,
             bus_b.vsync, bus_b.h_end, bus_b.v_end, bus_b.frame_start},
            model(k_b, 8, 2, 2, 2, 4, 1, 1, 1, 4));
    end
  end

  task automatic wait_a(input logic [9:0] x, input int limit, input string name);
    int n = 0;
    while (bus_a.pixel_x !== x && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, bus_a.pixel_x, x);
  endtask

  task automatic wait_b(input logic [9:0] x, input logic [9:0] y, input int limit,
                        input string name);
    int n = 0;
    while ((bus_b.pixel_x !== x || bus_b.pixel_y !== y) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, {bus_b.pixel_x, bus_b.pixel_y}, {x, y});
  endtask

  initial begin
    int n, lows;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk);
    #1 cmp_en = 1'b1;

    // Default mode: reset values, first tick, line structure.
    repeat (5) @(negedge clk);
    check("reset_x", bus_a.pixel_x, 0);
    check("reset_y", bus_a.pixel_y, 0);
    check("reset_syncs", {bus_a.hsync, bus_a.vsync, bus_a.p_tick, bus_a.video_on}, 4'b1101);
    rst_a = 1'b0;
    @(negedge clk);
    check("tick_edge1", bus_a.p_tick, 0);
    @(negedge clk);
    check("tick_edge2", bus_a.p_tick, 1);
    @(negedge clk);
    check("x_after_tick", {bus_a.p_tick, bus_a.pixel_x}, {1'b0, 10'd1});

    wait_a(10'd639, 2000, "reach_639");
    check("video_on_639", bus_a.video_on, 1);
    wait_a(10'd640, 10, "reach_640");
    check("video_off_640", bus_a.video_on, 0);
    wait_a(10'd656, 100, "reach_656");
    check("hsync_fall_656", bus_a.hsync, 0);
    n = 0;
    while (bus_a.hsync === 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("hsync_low_clks", n, 192);
    check("hsync_rise_x", bus_a.pixel_x, 752);
    wait_a(10'd799, 200, "reach_799");
    check("h_end_799", bus_a.h_end, 1);
    wait_a(10'd0, 10, "wrap_x");
    check("wrap_y", bus_a.pixel_y, 1);

    // Mid-line reset while hsync is low must clear outputs immediately.
    wait_a(10'd700, 2000, "reach_700");
    #2 rst_a = 1'b1;
    #1;
    check("midreset_a_xy", {bus_a.pixel_x, bus_a.pixel_y}, 0);
    check("midreset_a_sync", {bus_a.hsync, bus_a.vsync}, 2'b11);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    repeat (3300) @(negedge clk);
    rst_a = 1'b1;

    // Tiny mode: frame period and vsync width.
    @(negedge clk);
    rst_b = 1'b0;
    n = 0;
    while (bus_b.frame_start !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("first_frame_start", bus_b.frame_start, 1);
    n = 0;
    lows = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus_b.vsync === 1'b0) lows++;
    end while (bus_b.frame_start !== 1'b1 && n < 1000);
    check("frame_clks", n, 392);
    check("vsync_low_clks", lows, 56);

    // Reset with both syncs low.
    wait_b(10'd10, 10'd5, 1000, "reach_10_5");
    check("both_sync_low", {bus_b.hsync, bus_b.vsync}, 2'b00);
    #2 rst_b = 1'b1;
    #1;
    check("midreset_b", {bus_b.pixel_x, bus_b.pixel_y, bus_b.hsync, bus_b.vsync},
          {10'd0, 10'd0, 2'b11});

    // Random run lengths and asynchronous reset pulses.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst_b = 1'b0;
      repeat ($urandom_range(1, 500)) @(negedge clk);
      #($urandom_range(1, 4)) rst_b = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    repeat (450) @(negedge clk);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA timing from the 50 MHz system clock. It sits directly upstream of the text renderer and the top-level RGB register. It supplies the pixel tick, the pixel coordinates, video_on, and registered active-low hsync/vsync. The text generator and colour stages consume these outputs. All timing values are parameters, so other modes only require parameter overrides.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
TICK_DIV, 2, clk cycles per pixel (>=2)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
p_tick  out  1  one-clk pulse, once per TICK_DIV clks; the pixel enable
pixel_x  out  10  horizontal counter, 0..H_TOTAL-1
pixel_y  out  10  vertical counter, 0..V_TOTAL-1
video_on  out  1  high inside the visible area
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
h_end  out  1  high while pixel_x == H_TOTAL-1
v_end  out  1  high while pixel_y == V_TOTAL-1
frame_start  out  1  one-clk pulse on the p_tick that wraps the counters to (0,0)

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Reset (async, high):
  - div_cnt = 0, pixel_x = 0, pixel_y = 0.
  - p_tick = 0, frame_start = 0.
  - hsync = 1, vsync = 1.
  - video_on = 1, since (0,0) is visible.
  - Outputs hold these values while reset is asserted.
- Divider:
  - div_cnt counts 0..TICK_DIV-1 and wraps.
  - p_tick is registered: high for exactly the clk cycle after div_cnt reaches TICK_DIV-1.
  - First p_tick after reset release: clk edge TICK_DIV.
- Horizontal counter:
  - Advances only on clk edges where p_tick == 1.
  - Wraps from H_TOTAL-1 to 0.
- Vertical counter:
  - Increments on the same edge as the horizontal wrap.
  - Wraps from V_TOTAL-1 to 0 when both counters are at their last value.
- Sync timing:
  - hsync is registered and computed from the next counter values, so it stays cycle-aligned with pixel_x/pixel_y (no skew).
  - hsync = 0 iff pixel_x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vsync = 0 iff pixel_y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
- Combinational decodes from the counter registers:
  - video_on = (pixel_x < H_DISPLAY) && (pixel_y < V_DISPLAY).
  - h_end and v_end decode the last count of each counter.
- frame_start is registered. It is high for one clk on the edge where the counters move from (H_TOTAL-1, V_TOTAL-1) to (0,0). It is not asserted on reset release.
- Between ticks, all counters and sync outputs are stable for TICK_DIV clks.
- Width rule: counters are 10 bits. H_TOTAL and V_TOTAL must be <= 1024; this is checked by elaboration-time assertion.
- Reset mid-frame: all state returns to reset values immediately. Counting resumes from (0,0) on the normal divider schedule.

Test Plan:
- Hold reset 5 clks, then release -> during reset pixel_x=0, pixel_y=0, hsync=1, vsync=1, p_tick=0, video_on=1; first p_tick on clk edge 2 after release; p_tick period exactly 2 clks thereafter.
- Run one line -> pixel_x goes 0..799 then 0; pixel_y increments 0->1 on that wrap; video_on falls at pixel_x=640; h_end high only at 799.
- Measure hsync -> low from pixel_x=656 through 751 (96 ticks = 192 clks), high elsewhere; edges coincide with the tick that updates pixel_x.
- Run a full frame -> vsync low only for pixel_y=490..491 (1600 ticks); frame_start pulses once per 420000 ticks (840000 clks); v_end high only on line 524.
- Assert reset at pixel_x=700, pixel_y=491 (hsync and vsync both low) -> same clk: counters 0, hsync=vsync=1; after release, normal sequence restarts from (0,0).
- Override H_DISPLAY=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_DISPLAY=4, V_FRONT=1, V_SYNC=1, V_BACK=1, TICK_DIV=4 -> line length 14 ticks (56 clks); hsync low at x=10..11; vsync low at y=5; frame 98 ticks.
